alu_seq_unit: RTL and testbench

Parametrised multi-cycle ALU execute unit for the microprocessor datapath, fed by the instruction decoder with an operation code, carry-in or shift-in select, shift amount and two register operands. It adds a start/done handshake, an internal carry flag register and iterative multiply and shift sequencing, which the single-cycle decode path lacks. It sits between register-file read and write-back, and the control FSM stalls on `busy`.

---
 rtl/alu_seq_pkg.sv | 6 +
 rtl/alu_seq_if.sv | 13 +
 rtl/alu_seq_mul.sv | 29 ++
 rtl/alu_seq_unit.sv | 91 +++++++++
 tb/tb_alu_seq_unit.sv | 128 ++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode, carry-in select and FSM state encodings for alu_seq_unit
package alu_seq_pkg;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_MUL, OP_SHL, OP_SHR, OP_AND, OP_OR, OP_XOR} op_t;
  typedef enum logic [1:0] {CIN_ZERO, CIN_ONE, CIN_CARRY, CIN_MSB} cin_sel_t;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bus between the decoder-side control and alu_seq_unit
interface alu_seq_if import alu_seq_pkg::*; #(parameter int WIDTH = 16, parameter int SHW = $clog2(WIDTH));
  logic start;
  op_t op;
  cin_sel_t cin_sel;
  logic [SHW-1:0] shamt;
  logic [WIDTH-1:0] rn, rm;
  logic busy, done;
  logic [WIDTH-1:0] result;
  logic cout, carry;
  modport master(output start, op, cin_sel, shamt, rn, rm, input busy, done, result, cout, carry);
  modport slave(input start, op, cin_sel, shamt, rn, rm, output busy, done, result, cout, carry);
endinterface

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative unsigned shift-add multiplier, one step per cycle; prod_next is the post-step product
module alu_seq_mul #(parameter int WIDTH = 16) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod_next
);
  logic [WIDTH-1:0] a_q;
  logic [2*WIDTH-1:0] p_q;
  logic [WIDTH:0] sum;
  always_comb begin
    sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);
    prod_next = {sum, p_q[WIDTH-1:1]};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= '0;
      p_q <= '0;
    end else if (load) begin
      a_q <= a;
      p_q <= {{WIDTH{1'b0}}, b};
    end else if (step) begin
      p_q <= prod_next;
    end
  end
endmodule

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: multi-cycle ALU with carry flag; define ALU_SEQ_FAST_SHIFT_EN for single-cycle barrel shifts
module alu_seq_unit import alu_seq_pkg::*; #(parameter int WIDTH = 16, parameter int SHW = $clog2(WIDTH)) (
  input logic     clk,
  input logic     rst_n,
  alu_seq_if.slave bus
);
  state_t state, state_nxt;
  op_t op_q;
  cin_sel_t cin_q;
  logic [SHW-1:0] shamt_q;
  logic [WIDTH-1:0] rn_q, rm_q, result_q, res_nxt, sh_res;
  logic [SHW:0] cnt, last_cnt;
  logic cout_q, carry_q, cout_nxt, sh_c, fill, sub_cin, accept, exec_last;
  logic [WIDTH:0] add_w, sub_w;
  logic [2*WIDTH-1:0] prod_next;
  assign accept = state == IDLE && bus.start;
  assign exec_last = state == EXEC && cnt == last_cnt;
  assign fill = cin_q == CIN_ZERO ? 1'b0 : cin_q == CIN_ONE ? 1'b1 : cin_q == CIN_CARRY ? carry_q : rm_q[WIDTH-1];
  assign sub_cin = cin_q == CIN_ZERO ? 1'b1 : cin_q == CIN_ONE ? 1'b0 : cin_q == CIN_CARRY ? carry_q : ~rm_q[WIDTH-1];
  assign add_w = {1'b0, rn_q} + {1'b0, rm_q} + (WIDTH+1)'(fill);
  assign sub_w = {1'b0, rn_q} + {1'b0, ~rm_q} + (WIDTH+1)'(sub_cin);
`ifdef ALU_SEQ_FAST_SHIFT_EN
  logic [WIDTH:0] shl_w, shr_w;
  assign shl_w = (WIDTH+1)'(({1'b0, rm_q, {WIDTH{fill}}} << shamt_q) >> WIDTH);
  assign shr_w = (WIDTH+1)'({{WIDTH{fill}}, rm_q, 1'b0} >> shamt_q);
  assign sh_res = op_q == OP_SHL ? shl_w[WIDTH-1:0] : shr_w[WIDTH:1];
  assign sh_c = op_q == OP_SHL ? shl_w[WIDTH] : shr_w[0];
  assign last_cnt = op_q == OP_MUL ? (SHW+1)'(WIDTH-1) : '0;
`else
  logic [WIDTH-1:0] sh_q;
  assign sh_res = op_q == OP_SHL ? {sh_q[WIDTH-2:0], fill} : {fill, sh_q[WIDTH-1:1]};
  assign sh_c = op_q == OP_SHL ? sh_q[WIDTH-1] : sh_q[0];
  assign last_cnt = op_q == OP_MUL ? (SHW+1)'(WIDTH-1) :
                    (op_q == OP_SHL || op_q == OP_SHR) && shamt_q != '0 ? {1'b0, shamt_q} - 1'b1 : '0;
`endif
  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk(clk),
    .rst_n(rst_n),
    .load(accept),
    .step(state == EXEC && op_q == OP_MUL),
    .a(bus.rn),
    .b(bus.rm),
    .prod_next(prod_next)
  );
  assign state_nxt = state == IDLE ? (bus.start ? EXEC : IDLE) : state == EXEC ? (exec_last ? DONE : EXEC) : IDLE;
  always_comb begin
    {cout_nxt, res_nxt} = add_w;
    case (op_q)
      OP_SUB: {cout_nxt, res_nxt} = sub_w;
      OP_MUL: {cout_nxt, res_nxt} = {|prod_next[2*WIDTH-1:WIDTH], prod_next[WIDTH-1:0]};
      OP_SHL, OP_SHR: {cout_nxt, res_nxt} = shamt_q == '0 ? {carry_q, rm_q} : {sh_c, sh_res};
      OP_AND: {cout_nxt, res_nxt} = {carry_q, rn_q & rm_q};
      OP_OR: {cout_nxt, res_nxt} = {carry_q, rn_q | rm_q};
      OP_XOR: {cout_nxt, res_nxt} = {carry_q, rn_q ^ rm_q};
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      result_q <= '0;
      cout_q <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= state == EXEC ? cnt + 1'b1 : '0;
      if (accept) begin
        op_q <= bus.op;
        cin_q <= bus.cin_sel;
        shamt_q <= bus.shamt;
        rn_q <= bus.rn;
        rm_q <= bus.rm;
      end
`ifndef ALU_SEQ_FAST_SHIFT_EN
      if (accept) sh_q <= bus.rm;
      else if (state == EXEC) sh_q <= sh_res;
`endif
      if (exec_last) begin
        result_q <= res_nxt;
        cout_q <= cout_nxt;
        carry_q <= cout_nxt;
      end
    end
  end
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.result = result_q;
  assign bus.cout = cout_q;
  assign bus.carry = carry_q;
endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: directed vectors with a done-driven scoreboard for alu_seq_unit (WIDTH=16)
module tb_alu_seq_unit;
  import alu_seq_pkg::*;
  typedef struct {logic [15:0] r; logic c; logic k; int t;} exp_t;
`ifdef ALU_SEQ_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  exp_t q[$];
  alu_seq_if #(.WIDTH(16)) bus();
  alu_seq_unit #(.WIDTH(16)) dut(.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  function automatic int sh_lat(int s);
    return FAST ? 2 : (s == 0 ? 1 : s) + 1;
  endfunction
  always @(negedge clk) begin
    if (bus.done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got result %0h at cycle %0d with no operation pending", bus.result, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", 32'(bus.result), 32'(e.r));
        chk("cout", 32'(bus.cout), 32'(e.c));
        chk("carry", 32'(bus.carry), 32'(e.k));
        chk("done_cycle", cyc, e.t);
      end
    end
  end
  task automatic wait_idle(int poke);
    int i = 0;
    while (bus.busy && i < 60) begin
      bus.start = (i == poke);
      @(negedge clk);
      i++;
    end
    bus.start = 1'b0;
    if (bus.busy) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: busy still %0b after %0d cycles, required 0", bus.busy, i);
    end
  endtask
  task automatic issue(op_t o, cin_sel_t s, logic [3:0] sh, logic [15:0] a, logic [15:0] b,
                       logic [15:0] er, logic ec, logic ek, int lat, int poke);
    @(negedge clk);
    bus.op = o; bus.cin_sel = s; bus.shamt = sh; bus.rn = a; bus.rm = b; bus.start = 1'b1;
    @(posedge clk);
    #1;
    q.push_back('{er, ec, ek, cyc + lat - 1});
    @(negedge clk);
    bus.start = 1'b0; bus.op = OP_ADD; bus.rn = 16'hDEAD; bus.rm = 16'hBEEF; bus.shamt = 4'd9;
    wait_idle(poke);
  endtask
  initial begin
    bus.start = 1'b0; bus.op = OP_ADD; bus.cin_sel = CIN_ZERO; bus.shamt = '0; bus.rn = '0; bus.rm = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_result", 32'(bus.result), 0);
    chk("rst_cout", 32'(bus.cout), 0);
    chk("rst_carry", 32'(bus.carry), 0);
    rst_n = 1'b1;
    issue(OP_ADD, CIN_ZERO, 4'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 2, -1);
    issue(OP_ADD, CIN_CARRY, 4'd0, 16'h0001, 16'h0001, 16'h0003, 1'b0, 1'b0, 2, -1);
    issue(OP_SUB, CIN_ZERO, 4'd0, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 2, -1);
    issue(OP_SUB, CIN_ZERO, 4'd0, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b1, 2, -1);
    // start held high: dropped in DONE, re-accepted one cycle later
    @(negedge clk);
    bus.op = OP_ADD; bus.cin_sel = CIN_ZERO; bus.rn = 16'h0001; bus.rm = 16'h0002; bus.start = 1'b1;
    @(posedge clk);
    #1;
    q.push_back('{16'h0003, 1'b0, 1'b0, cyc + 1});
    q.push_back('{16'h0003, 1'b0, 1'b0, cyc + 4});
    repeat (3) @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    wait_idle(-1);
    issue(OP_ADD, CIN_MSB, 4'd0, 16'h7000, 16'h8000, 16'hF001, 1'b0, 1'b0, 2, -1);
    issue(OP_SUB, CIN_CARRY, 4'd0, 16'h0010, 16'h0001, 16'h000E, 1'b1, 1'b1, 2, -1);
    issue(OP_AND, CIN_ZERO, 4'd0, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b1, 1'b1, 2, -1);
    issue(OP_OR, CIN_ZERO, 4'd0, 16'hF0F0, 16'h3C3C, 16'hFCFC, 1'b1, 1'b1, 2, -1);
    issue(OP_MUL, CIN_ZERO, 4'd0, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1, 17, 4);
    issue(OP_MUL, CIN_ZERO, 4'd0, 16'h00FF, 16'h0003, 16'h02FD, 1'b0, 1'b0, 17, -1);
    issue(OP_SHR, CIN_MSB, 4'd4, 16'h0000, 16'h8001, 16'hF800, 1'b0, 1'b0, sh_lat(4), -1);
    issue(OP_SHL, CIN_ONE, 4'd1, 16'h0000, 16'h8001, 16'h0003, 1'b1, 1'b1, sh_lat(1), -1);
    issue(OP_SHR, CIN_CARRY, 4'd3, 16'h0000, 16'h00F0, 16'hE01E, 1'b0, 1'b0, sh_lat(3), -1);
    issue(OP_SHL, CIN_ZERO, 4'd15, 16'h0000, 16'h0001, 16'h8000, 1'b0, 1'b0, sh_lat(15), -1);
    issue(OP_SHL, CIN_ONE, 4'd1, 16'h0000, 16'h8001, 16'h0003, 1'b1, 1'b1, sh_lat(1), -1);
    issue(OP_SHL, CIN_ZERO, 4'd0, 16'h0000, 16'h1234, 16'h1234, 1'b1, 1'b1, sh_lat(0), -1);
    issue(OP_XOR, CIN_ZERO, 4'd0, 16'hAAAA, 16'hFFFF, 16'h5555, 1'b1, 1'b1, 2, -1);
    // reset in the middle of a multiply: aborted, no done afterwards
    @(negedge clk);
    bus.op = OP_MUL; bus.rn = 16'h0003; bus.rm = 16'h0005; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mul_busy_before_rst", 32'(bus.busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_done", 32'(bus.done), 0);
    chk("abort_result", 32'(bus.result), 0);
    chk("abort_carry", 32'(bus.carry), 0);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("abort_idle", 32'(bus.busy), 0);
    chk("pending_left", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
